// File: rtl/axi_arb_pkg.sv
// Shared types and AXI encodings for the IFU/LSU memory arbiter.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR0,
        ST_R0,
        ST_AR1,
        ST_R1,
        ST_WR,
        ST_B
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [3:0] ARB_ID_IFU     = 4'd0;
    localparam logic [3:0] ARB_ID_LSU     = 4'd1;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// Bus bundle for the arbiter: M0 (IFU), M1 (LSU) and the shared slave.
// master = arbiter view (it masters the slave); slave = core + memory side.
interface axi_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              m0_arvalid;
    logic [ADDR_W-1:0] m0_araddr;
    logic [7:0]        m0_arlen;
    logic              m0_arready;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rlast;
    logic [1:0]        m0_rresp;
    logic              m0_rready;

    logic              m1_arvalid;
    logic [ADDR_W-1:0] m1_araddr;
    logic [7:0]        m1_arlen;
    logic              m1_arready;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rlast;
    logic [1:0]        m1_rresp;
    logic              m1_rready;
    logic              m1_awvalid;
    logic [ADDR_W-1:0] m1_awaddr;
    logic              m1_awready;
    logic              m1_wvalid;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W/8-1:0] m1_wstrb;
    logic              m1_wready;
    logic              m1_bvalid;
    logic [1:0]        m1_bresp;
    logic              m1_bready;

    logic              s_arvalid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [3:0]        s_arid;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arready;
    logic              s_rvalid;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rlast;
    logic [1:0]        s_rresp;
    logic              s_rready;
    logic              s_awvalid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0]        s_awlen;
    logic              s_awready;
    logic              s_wvalid;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic              s_wlast;
    logic              s_wready;
    logic              s_bvalid;
    logic [1:0]        s_bresp;
    logic              s_bready;

    modport master (
        input  m0_arvalid, m0_araddr, m0_arlen, m0_rready,
        output m0_arready, m0_rvalid, m0_rdata, m0_rlast, m0_rresp,
        input  m1_arvalid, m1_araddr, m1_arlen, m1_rready,
        output m1_arready, m1_rvalid, m1_rdata, m1_rlast, m1_rresp,
        input  m1_awvalid, m1_awaddr, m1_wvalid, m1_wdata, m1_wstrb,
        input  m1_bready,
        output m1_awready, m1_wready, m1_bvalid, m1_bresp,
        output s_arvalid, s_araddr, s_arlen, s_arid, s_arsize, s_arburst,
        input  s_arready,
        input  s_rvalid, s_rdata, s_rlast, s_rresp,
        output s_rready,
        output s_awvalid, s_awaddr, s_awlen,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bresp,
        output s_bready
    );

    modport slave (
        output m0_arvalid, m0_araddr, m0_arlen, m0_rready,
        input  m0_arready, m0_rvalid, m0_rdata, m0_rlast, m0_rresp,
        output m1_arvalid, m1_araddr, m1_arlen, m1_rready,
        input  m1_arready, m1_rvalid, m1_rdata, m1_rlast, m1_rresp,
        output m1_awvalid, m1_awaddr, m1_wvalid, m1_wdata, m1_wstrb,
        output m1_bready,
        input  m1_awready, m1_wready, m1_bvalid, m1_bresp,
        input  s_arvalid, s_araddr, s_arlen, s_arid, s_arsize, s_arburst,
        output s_arready,
        output s_rvalid, s_rdata, s_rlast, s_rresp,
        input  s_rready,
        input  s_awvalid, s_awaddr, s_awlen,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bresp,
        input  s_bready
    );

endinterface

// File: rtl/axi_mem_arbiter.sv
// Single-outstanding AXI arbiter: LSU write first, round-robin reads,
// responses steered by FSM state, sticky watchdog on R/B waits.
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_mem_arbiter_if.master bus,
    output logic              timeout_err
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e state;
    arb_state_e state_nx;
    logic       rr_ptr;
    logic       rr_ptr_nx;
    logic       aw_done;
    logic       aw_done_nx;
    logic       w_done;
    logic       w_done_nx;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_nx;
    logic [WD_W-1:0] wd_inc;
    logic       waiting;
    logic       wait_hs;
    logic       timeout_nx;

    assign bus.s_arsize  = AXI_SIZE_8B;
    assign bus.s_arburst = AXI_BURST_INCR;
    assign bus.s_awaddr  = bus.m1_awaddr;
    assign bus.s_awlen   = 8'd0;
    assign bus.s_wdata   = bus.m1_wdata;
    assign bus.s_wstrb   = bus.m1_wstrb;
    assign bus.s_wlast   = 1'b1;
    assign bus.m0_rdata  = bus.s_rdata;
    assign bus.m0_rlast  = bus.s_rlast;
    assign bus.m0_rresp  = bus.s_rresp;
    assign bus.m1_rdata  = bus.s_rdata;
    assign bus.m1_rlast  = bus.s_rlast;
    assign bus.m1_rresp  = bus.s_rresp;
    assign bus.m1_bresp  = bus.s_bresp;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_ptr_nx;
            aw_done     <= aw_done_nx;
            w_done      <= w_done_nx;
            wd_cnt      <= wd_cnt_nx;
            timeout_err <= timeout_nx;
        end
    end

    // Handshake terms come straight from inputs to avoid a comb loop
    always_comb begin
        waiting = 1'b0;
        wait_hs = 1'b0;
        unique case (1'b1)
            state == ST_R0: begin
                waiting = 1'b1;
                wait_hs = bus.s_rvalid & bus.m0_rready;
            end
            state == ST_R1: begin
                waiting = 1'b1;
                wait_hs = bus.s_rvalid & bus.m1_rready;
            end
            state == ST_B: begin
                waiting = 1'b1;
                wait_hs = bus.s_bvalid & bus.m1_bready;
            end
            default: ;
        endcase
        wd_inc = wd_cnt + 1'b1;
        if (!waiting || wait_hs) begin
            wd_cnt_nx = '0;
        end else if (wd_cnt != WD_W'(TIMEOUT)) begin
            wd_cnt_nx = wd_inc;
        end else begin
            wd_cnt_nx = wd_cnt;
        end
        timeout_nx = timeout_err
                   | ((TIMEOUT != 0) & waiting & ~wait_hs
                      & (wd_inc == WD_W'(TIMEOUT)));
    end

    always_comb begin
        state_nx       = state;
        rr_ptr_nx      = rr_ptr;
        aw_done_nx     = aw_done;
        w_done_nx      = w_done;
        bus.m0_arready = 1'b0;
        bus.m0_rvalid  = 1'b0;
        bus.m1_arready = 1'b0;
        bus.m1_rvalid  = 1'b0;
        bus.m1_awready = 1'b0;
        bus.m1_wready  = 1'b0;
        bus.m1_bvalid  = 1'b0;
        bus.s_arvalid  = 1'b0;
        bus.s_araddr   = bus.m0_araddr;
        bus.s_arlen    = bus.m0_arlen;
        bus.s_arid     = ARB_ID_IFU;
        bus.s_rready   = 1'b0;
        bus.s_awvalid  = 1'b0;
        bus.s_wvalid   = 1'b0;
        bus.s_bready   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                aw_done_nx = 1'b0;
                w_done_nx  = 1'b0;
                if (bus.m1_awvalid && bus.m1_wvalid) begin
                    state_nx = ST_WR;
                end else if (bus.m0_arvalid && bus.m1_arvalid) begin
                    state_nx = rr_ptr ? ST_AR1 : ST_AR0;
                end else if (bus.m0_arvalid) begin
                    state_nx = ST_AR0;
                end else if (bus.m1_arvalid) begin
                    state_nx = ST_AR1;
                end
            end
            ST_AR0: begin
                bus.s_arvalid  = bus.m0_arvalid;
                bus.m0_arready = bus.s_arready;
                if (bus.m0_arvalid && bus.s_arready) begin
                    state_nx = ST_R0;
                end
            end
            ST_R0: begin
                bus.m0_rvalid = bus.s_rvalid;
                bus.s_rready  = bus.m0_rready;
                if (bus.s_rvalid && bus.m0_rready && bus.s_rlast) begin
                    state_nx  = ST_IDLE;
                    rr_ptr_nx = 1'b1;
                end
            end
            ST_AR1: begin
                bus.s_arvalid  = bus.m1_arvalid;
                bus.s_araddr   = bus.m1_araddr;
                bus.s_arlen    = bus.m1_arlen;
                bus.s_arid     = ARB_ID_LSU;
                bus.m1_arready = bus.s_arready;
                if (bus.m1_arvalid && bus.s_arready) begin
                    state_nx = ST_R1;
                end
            end
            ST_R1: begin
                bus.m1_rvalid = bus.s_rvalid;
                bus.s_rready  = bus.m1_rready;
                if (bus.s_rvalid && bus.m1_rready && bus.s_rlast) begin
                    state_nx  = ST_IDLE;
                    rr_ptr_nx = 1'b0;
                end
            end
            ST_WR: begin
                bus.s_awvalid  = bus.m1_awvalid & ~aw_done;
                bus.s_wvalid   = bus.m1_wvalid & ~w_done;
                bus.m1_awready = bus.s_awready & ~aw_done;
                bus.m1_wready  = bus.s_wready & ~w_done;
                aw_done_nx = aw_done | (bus.s_awvalid & bus.s_awready);
                w_done_nx  = w_done | (bus.s_wvalid & bus.s_wready);
                if (aw_done_nx && w_done_nx) begin
                    state_nx = ST_B;
                end
            end
            ST_B: begin
                bus.m1_bvalid = bus.s_bvalid;
                bus.s_bready  = bus.m1_bready;
                if (bus.s_bvalid && bus.m1_bready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter with an inline SRAM slave model.
module tb_axi_mem_arbiter;
    import axi_arb_pkg::*;

    localparam int TMO = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic aclk = 1'b0;
    logic aresetn;
    logic timeout_err;

    axi_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi_mem_arbiter #(.TIMEOUT(TMO)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .bus         (bus.master),
        .timeout_err (timeout_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } sx_t;
    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;
    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
    } wbeat_t;

    sx_t    qs[$];
    beat_t  q0[$];
    beat_t  q1[$];
    wbeat_t qw[$];
    int     qb;
    int     n_chk = 0;
    int     n_bad = 0;
    logic [63:0] exp_mem [32];
    logic   hold_b;
    logic   w_lag;
    logic   tog;

    function automatic logic [63:0] pat(input int i);
        return {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i * 16)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // SRAM slave: one read burst at a time, write applied once AW and W land
    logic [63:0] mem [32];
    logic        rbusy;
    logic [4:0]  ridx;
    logic [7:0]  rcnt;
    logic [7:0]  rlen;
    logic        awgot;
    logic        wgot;
    logic        bpend;
    logic [31:0] wa;
    logic [63:0] wdat;
    logic [7:0]  wstb;

    assign bus.s_arready = !rbusy;
    assign bus.s_rvalid  = rbusy;
    assign bus.s_rdata   = mem[ridx + rcnt[4:0]];
    assign bus.s_rlast   = rbusy && (rcnt == rlen);
    assign bus.s_rresp   = RESP_OKAY;
    assign bus.s_awready = !awgot && !bpend;
    assign bus.s_wready  = !wgot && !bpend && (!w_lag || awgot);
    assign bus.s_bvalid  = bpend && !hold_b;
    assign bus.s_bresp   = RESP_OKAY;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rbusy <= 1'b0;
            ridx  <= '0;
            rcnt  <= '0;
            rlen  <= '0;
            awgot <= 1'b0;
            wgot  <= 1'b0;
            bpend <= 1'b0;
            wa    <= '0;
            wdat  <= '0;
            wstb  <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= pat(i);
        end else begin
            if (bus.s_arvalid && bus.s_arready) begin
                rbusy <= 1'b1;
                ridx  <= bus.s_araddr[7:3];
                rcnt  <= '0;
                rlen  <= bus.s_arlen;
            end else if (bus.s_rvalid && bus.s_rready) begin
                if (bus.s_rlast) rbusy <= 1'b0;
                else rcnt <= rcnt + 8'd1;
            end
            if (bus.s_awvalid && bus.s_awready) begin
                awgot <= 1'b1;
                wa    <= bus.s_awaddr;
            end
            if (bus.s_wvalid && bus.s_wready) begin
                wgot <= 1'b1;
                wdat <= bus.s_wdata;
                wstb <= bus.s_wstrb;
            end
            if (awgot && wgot) begin
                for (int b = 0; b < 8; b++) begin
                    if (wstb[b]) mem[wa[7:3]][8*b +: 8] <= wdat[8*b +: 8];
                end
                awgot <= 1'b0;
                wgot  <= 1'b0;
                bpend <= 1'b1;
            end
            if (bus.s_bvalid && bus.s_bready) bpend <= 1'b0;
        end
    end

    // Monitor: pops expectations whenever a handshake is presented
    always @(negedge aclk) begin
        sx_t    s;
        beat_t  e;
        wbeat_t w;
        if (aresetn) begin
            if (bus.m0_rvalid && bus.m0_rready) begin
                if (q0.size() == 0) begin
                    chk("m0_r_unexpected", 64'(q0.size()), 64'd1);
                end else begin
                    e = q0.pop_front();
                    chk("m0_rdata", bus.m0_rdata, e.data);
                    chk("m0_rlast", 64'(bus.m0_rlast), 64'(e.last));
                    chk("m0_rresp", 64'(bus.m0_rresp), 64'(RESP_OKAY));
                end
            end
            if (bus.m1_rvalid && q1.size() == 0) begin
                chk("m1_rvalid_idle", 64'(bus.m1_rvalid), 64'd0);
            end else if (bus.m1_rvalid && bus.m1_rready) begin
                e = q1.pop_front();
                chk("m1_rdata", bus.m1_rdata, e.data);
                chk("m1_rlast", 64'(bus.m1_rlast), 64'(e.last));
                chk("m1_rresp", 64'(bus.m1_rresp), 64'(RESP_OKAY));
            end
            if (bus.s_arvalid && bus.s_arready) begin
                if (qs.size() == 0) begin
                    chk("ar_unexpected", 64'(qs.size()), 64'd1);
                end else begin
                    s = qs.pop_front();
                    chk("ar_kind", 64'(s.is_wr), 64'd0);
                    chk("ar_addr", 64'(bus.s_araddr), 64'(s.addr));
                    chk("ar_len", 64'(bus.s_arlen), 64'(s.len));
                    chk("ar_id", 64'(bus.s_arid), 64'(s.id));
                    chk("ar_size", 64'(bus.s_arsize), 64'd3);
                    chk("ar_burst", 64'(bus.s_arburst), 64'd1);
                end
            end
            if (bus.s_awvalid && bus.s_awready) begin
                if (qs.size() == 0) begin
                    chk("aw_unexpected", 64'(qs.size()), 64'd1);
                end else begin
                    s = qs.pop_front();
                    chk("aw_kind", 64'(s.is_wr), 64'd1);
                    chk("aw_addr", 64'(bus.s_awaddr), 64'(s.addr));
                    chk("aw_len", 64'(bus.s_awlen), 64'd0);
                end
            end
            if (bus.s_wvalid && bus.s_wready) begin
                if (qw.size() == 0) begin
                    chk("w_unexpected", 64'(qw.size()), 64'd1);
                end else begin
                    w = qw.pop_front();
                    chk("w_data", bus.s_wdata, w.data);
                    chk("w_strb", 64'(bus.s_wstrb), 64'(w.strb));
                    chk("w_last", 64'(bus.s_wlast), 64'd1);
                end
            end
            if (bus.m1_bvalid && bus.m1_bready) begin
                chk("b_expected", 64'(qb), 64'd1);
                if (qb > 0) qb--;
                chk("b_resp", 64'(bus.m1_bresp), 64'(RESP_OKAY));
            end
        end
    end

    initial begin
        bus.m1_rready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus.m1_rready = tog ? ~bus.m1_rready : 1'b1;
        end
    end

    task automatic exp_rd(input int m, input logic [31:0] a,
                          input logic [7:0] l);
        sx_t   s;
        beat_t b;
        s.is_wr = 1'b0;
        s.addr  = a;
        s.len   = l;
        s.id    = (m != 0) ? ARB_ID_LSU : ARB_ID_IFU;
        qs.push_back(s);
        for (int i = 0; i <= int'(l); i++) begin
            b.data = exp_mem[(int'(a[7:3]) + i) % 32];
            b.last = (i == int'(l));
            if (m != 0) q1.push_back(b);
            else q0.push_back(b);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] st);
        sx_t    s;
        wbeat_t w;
        s.is_wr = 1'b1;
        s.addr  = a;
        s.len   = 8'd0;
        s.id    = 4'd0;
        qs.push_back(s);
        w.data = d;
        w.strb = st;
        qw.push_back(w);
        qb++;
    endtask

    task automatic rd0(input logic [31:0] a, input logic [7:0] l);
        int n = 0;
        bus.m0_arvalid = 1'b1;
        bus.m0_araddr  = a;
        bus.m0_arlen   = l;
        do begin
            @(negedge aclk);
            n++;
        end while (!bus.m0_arready && n < 60);
        chk("m0_ar_grant", 64'(bus.m0_arready), 64'd1);
        @(posedge aclk);
        #1;
        bus.m0_arvalid = 1'b0;
    endtask

    task automatic rd1(input logic [31:0] a, input logic [7:0] l);
        int n = 0;
        bus.m1_arvalid = 1'b1;
        bus.m1_araddr  = a;
        bus.m1_arlen   = l;
        do begin
            @(negedge aclk);
            n++;
        end while (!bus.m1_arready && n < 60);
        chk("m1_ar_grant", 64'(bus.m1_arready), 64'd1);
        @(posedge aclk);
        #1;
        bus.m1_arvalid = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] st);
        int   n = 0;
        logic aw_hs;
        logic w_hs;
        bus.m1_awvalid = 1'b1;
        bus.m1_awaddr  = a;
        bus.m1_wvalid  = 1'b1;
        bus.m1_wdata   = d;
        bus.m1_wstrb   = st;
        while ((bus.m1_awvalid || bus.m1_wvalid) && n < 60) begin
            @(negedge aclk);
            aw_hs = bus.m1_awvalid && bus.m1_awready;
            w_hs  = bus.m1_wvalid && bus.m1_wready;
            @(posedge aclk);
            #1;
            if (aw_hs) bus.m1_awvalid = 1'b0;
            if (w_hs) bus.m1_wvalid = 1'b0;
            n++;
        end
        chk("m1_aw_w_grant", 64'({bus.m1_awvalid, bus.m1_wvalid}), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() + q1.size() + qs.size() + qw.size() + qb) != 0
               && n < 200) begin
            @(posedge aclk);
            n++;
        end
        chk("drain", 64'(q0.size() + q1.size() + qs.size() + qw.size() + qb),
            64'd0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    function automatic logic [11:0] out_vec();
        return {bus.m0_arready, bus.m1_arready, bus.m0_rvalid,
                bus.m1_rvalid, bus.m1_awready, bus.m1_wready,
                bus.m1_bvalid, bus.s_arvalid, bus.s_rready,
                bus.s_awvalid, bus.s_wvalid, bus.s_bready};
    endfunction

    initial begin
        int n;
        bus.m0_arvalid = 1'b0;
        bus.m0_araddr  = '0;
        bus.m0_arlen   = '0;
        bus.m0_rready  = 1'b1;
        bus.m1_arvalid = 1'b0;
        bus.m1_araddr  = '0;
        bus.m1_arlen   = '0;
        bus.m1_awvalid = 1'b0;
        bus.m1_awaddr  = '0;
        bus.m1_wvalid  = 1'b0;
        bus.m1_wdata   = '0;
        bus.m1_wstrb   = '0;
        bus.m1_bready  = 1'b1;
        hold_b = 1'b0;
        w_lag  = 1'b0;
        tog    = 1'b0;
        qb     = 0;
        for (int i = 0; i < 32; i++) exp_mem[i] = pat(i);
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_outputs", 64'(out_vec()), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // tie from reset: M0 then M1
        exp_rd(0, BASE + 32'h08, 8'd1);
        exp_rd(1, BASE + 32'h18, 8'd0);
        fork
            rd0(BASE + 32'h08, 8'd1);
            rd1(BASE + 32'h18, 8'd0);
        join
        wait_idle();

        // M0 alone, single beat
        exp_rd(0, BASE, 8'd0);
        rd0(BASE, 8'd0);
        wait_idle();

        // tie again: pointer now favours M1
        exp_rd(1, BASE + 32'h28, 8'd0);
        exp_rd(0, BASE + 32'h30, 8'd2);
        fork
            rd0(BASE + 32'h30, 8'd2);
            rd1(BASE + 32'h28, 8'd0);
        join
        wait_idle();

        // write beats a concurrent read of the same word
        exp_wr(BASE + 32'h10, 64'h1122_3344_5566_7788, 8'h0F);
        exp_mem[2] = 64'hA000_0002_5566_7788;
        exp_rd(0, BASE + 32'h10, 8'd0);
        fork
            wr1(BASE + 32'h10, 64'h1122_3344_5566_7788, 8'h0F);
            rd0(BASE + 32'h10, 8'd0);
        join
        wait_idle();

        // M1 burst with throttled rready; M0 must stall
        exp_rd(1, BASE + 32'h20, 8'd3);
        exp_rd(0, BASE, 8'd0);
        tog = 1'b1;
        rd1(BASE + 32'h20, 8'd3);
        fork
            rd0(BASE, 8'd0);
            begin
                n = 0;
                while (q1.size() != 0 && n < 100) begin
                    @(negedge aclk);
                    chk("m0_stall", 64'(bus.m0_arready), 64'd0);
                    n++;
                end
            end
        join
        tog = 1'b0;
        wait_idle();

        // reset while R1 presents beat 2
        exp_rd(1, BASE + 32'h40, 8'd3);
        rd1(BASE + 32'h40, 8'd3);
        n = 0;
        while (q1.size() != 3 && n < 50) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("mid_beat2_valid", 64'(bus.m1_rvalid), 64'd1);
        chk("mid_beat2_data", bus.m1_rdata, exp_mem[9]);
        #1;
        aresetn = 1'b0;
        #1;
        chk("async_rst_outputs", 64'(out_vec()), 64'd0);
        q0.delete();
        q1.delete();
        qs.delete();
        qw.delete();
        qb = 0;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        exp_rd(0, BASE + 32'h08, 8'd0);
        rd0(BASE + 32'h08, 8'd0);
        wait_idle();

        // watchdog: B held off, separate AW/W handshakes
        chk("pre_timeout", 64'(timeout_err), 64'd0);
        hold_b = 1'b1;
        w_lag  = 1'b1;
        exp_wr(BASE + 32'h48, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
        wr1(BASE + 32'h48, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
        repeat (6) @(posedge aclk);
        #1;
        chk("timeout_early", 64'(timeout_err), 64'd0);
        repeat (4) @(posedge aclk);
        #1;
        chk("timeout_set", 64'(timeout_err), 64'd1);
        hold_b = 1'b0;
        wait_idle();
        chk("timeout_sticky", 64'(timeout_err), 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

endmodule
